// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the shift-counter sequencer.
// Mode, direction and FSM state values used by the top and the core.
package shift_seq_ctrl_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command/status bundle between a controller and the shift sequencer.
// The controller owns the master side, the sequencer the slave side.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic             mode;
  logic             dir;
  logic [CNT_W-1:0] steps;
  logic             pause;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output start, mode, dir, steps, pause,
    input  out, busy, done, wrap
  );

  modport slave (
    input  start, mode, dir, steps, pause,
    output out, busy, done, wrap
  );
endinterface

// File: rtl/shift_seq_ctrl_core.sv
// Ring/Johnson shift register: seed load, one-step shift, seed-match flag.
// hit_o flags that the pattern about to be written equals the seed.
module shift_core
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             mode_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] out_o,
  output logic             hit_o
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] seed, nxt;

  always_comb begin
    seed = (mode_i == MODE_JOHNSON) ? '0 : WIDTH'(1);
  end

  always_comb begin
    nxt = out_q;
    unique case ({mode_i, dir_i})
      {MODE_RING, DIR_LEFT}:
        nxt = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
      {MODE_RING, DIR_RIGHT}:
        nxt = {out_q[0], out_q[WIDTH-1:1]};
      {MODE_JOHNSON, DIR_LEFT}:
        nxt = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
      {MODE_JOHNSON, DIR_RIGHT}:
        nxt = {~out_q[0], out_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    out_d = out_q;
    unique case (1'b1)
      load_i:  out_d = seed;
      shift_i: out_d = nxt;
      default: out_d = out_q;
    endcase
  end

  assign hit_o = shift_i && (nxt == seed);

  always_ff @(posedge clk) begin
    if (reset) out_q <= '0;
    else       out_q <= out_d;
  end

  assign out_o = out_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer: accepts a command, seeds the core, then shifts N times.
// Owns the FSM, remaining count and the busy/done/wrap flags.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  shift_seq_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             load, shift, hit;
  logic             core_mode;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load   = 1'b1;
          mode_d = bus.mode;
          dir_d  = bus.dir;
          if (bus.steps != '0) begin
            rem_d   = bus.steps;
            busy_d  = 1'b1;
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!bus.pause) begin
          shift  = 1'b1;
          rem_d  = rem_q - CNT_W'(1);
          wrap_d = hit;
          if (rem_q == CNT_W'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  // Seed choice follows the incoming command; shifts use the latched mode.
  assign core_mode = load ? bus.mode : mode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      mode_q  <= MODE_RING;
      dir_q   <= DIR_LEFT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  shift_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .shift_i (shift),
    .mode_i  (core_mode),
    .dir_i   (dir_q),
    .out_o   (bus.out),
    .hit_o   (hit)
  );

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed and random checks of shift_seq_ctrl against a position-index model.
// The model derives each pattern from the shift count, not from shifting bits.
module tb_shift_seq_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  string sec = "init";

  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.WIDTH(4), .CNT_W(8)) bus ();

  shift_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [3:0] m_out;
  logic       m_busy, m_done, m_wrap, m_mode, m_dir;
  int         m_rem, m_pos;

  function automatic logic [3:0] pat(logic md, logic dr, int p);
    if (!md) return dr ? 4'(1 << ((4 - p) % 4)) : 4'(1 << p);
    if (!dr) return (p <= 4) ? 4'((1 << p) - 1) : 4'((15 << (p - 4)) & 15);
    return (p <= 4) ? 4'((15 << (4 - p)) & 15) : 4'(15 >> (p - 4));
  endfunction

  task automatic model_edge(input logic r, input logic st, input logic md,
                            input logic dr, input logic [7:0] stp,
                            input logic ps);
    m_done = 1'b0;
    m_wrap = 1'b0;
    if (r) begin
      m_out = 4'd0; m_busy = 1'b0; m_rem = 0;
    end else if (!m_busy) begin
      if (st) begin
        m_mode = md; m_dir = dr; m_pos = 0;
        m_out = pat(md, dr, 0);
        if (stp != 8'd0) begin
          m_rem = int'(stp); m_busy = 1'b1;
        end else begin
          m_done = 1'b1;
        end
      end
    end else if (!ps) begin
      m_pos = (m_pos + 1) % (m_mode ? 8 : 4);
      m_out = pat(m_mode, m_dir, m_pos);
      m_wrap = (m_pos == 0);
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s: got %0h want %0h", sec, tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic st, input logic md,
                     input logic dr, input logic [7:0] stp, input logic ps);
    @(negedge clk);
    reset = r; bus.start = st; bus.mode = md; bus.dir = dr;
    bus.steps = stp; bus.pause = ps;
    @(posedge clk);
    model_edge(r, st, md, dr, stp, ps);
    #1;
    chk("out",  32'(bus.out),  32'(m_out));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("wrap", 32'(bus.wrap), 32'(m_wrap));
  endtask

  task automatic idle_run(input logic ps);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, ps);
  endtask

  int n, n_np, n_p, busy_cnt, wraps;
  logic [3:0] exp2 [9];

  initial begin
    m_out = '0; m_busy = 0; m_done = 0; m_wrap = 0;
    m_mode = 0; m_dir = 0; m_rem = 0; m_pos = 0;
    bus.start = 0; bus.mode = 0; bus.dir = 0; bus.steps = 0; bus.pause = 0;

    sec = "reset";
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    chk("out0", 32'(bus.out), 32'h0);

    sec = "johnL8";
    exp2 = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'd8, 1'b0);
    chk("seed", 32'(bus.out), 32'(exp2[0]));
    for (int i = 1; i <= 8; i++) begin
      idle_run(1'b0);
      chk("seq", 32'(bus.out), 32'(exp2[i]));
    end
    chk("wrap_end", 32'(bus.wrap), 32'd1);
    chk("done_end", 32'(bus.done), 32'd1);

    sec = "ringR5";
    busy_cnt = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'd5, 1'b0);
    if (bus.busy) busy_cnt++;
    for (int i = 0; i < 5; i++) begin
      idle_run(1'b0);
      if (bus.busy) busy_cnt++;
    end
    chk("final", 32'(bus.out), 32'h8);
    chk("busy_cycles", 32'(busy_cnt), 32'd5);

    sec = "pause";
    for (int pass = 0; pass < 2; pass++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd6, 1'b0);
      n = 0;
      while (!bus.done && n < 40) begin
        idle_run((pass == 1) && n >= 2 && n < 5);
        n++;
      end
      chk("done_seen", 32'(bus.done), 32'd1);
      if (pass == 0) n_np = n; else n_p = n;
    end
    chk("nopause_len", 32'(n_np), 32'd6);
    chk("pause_delta", 32'(n_p - n_np), 32'd3);

    sec = "zero";
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    chk("seed", 32'(bus.out), 32'h1);
    chk("done", 32'(bus.done), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0);
    chk("accept", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 3; i++) idle_run(1'b0);
    chk("end", 32'(bus.out), 32'h8);

    sec = "abort";
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd6, 1'b0);
    idle_run(1'b0);
    idle_run(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    chk("out", 32'(bus.out), 32'h0);
    idle_run(1'b0);
    chk("no_done", 32'(bus.done), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0);
    idle_run(1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'd200, 1'b0);
    n = 2;
    while (!bus.done && n < 40) begin
      idle_run(1'b0);
      n++;
    end
    chk("ignored_len", 32'(n), 32'd4);
    chk("ignored_out", 32'(bus.out), 32'h1);

    sec = "max";
    wraps = 0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd255, 1'b0);
    for (int i = 0; i < 255; i++) begin
      idle_run(1'b0);
      if (bus.wrap) wraps++;
    end
    chk("done", 32'(bus.done), 32'd1);
    chk("wraps", 32'(wraps), 32'(255 / 4));
    idle_run(1'b0);
    chk("hold", 32'(bus.out), 32'h8);

    sec = "random";
    for (int i = 0; i < 800; i++) begin
      logic r, st, md, dr, ps;
      logic [7:0] stp;
      r  = ($urandom_range(0, 63) == 0);
      st = ($urandom_range(0, 2) == 0);
      md = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      ps = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) stp = 8'($urandom_range(0, 255));
      else stp = 8'($urandom_range(0, 10));
      cyc(r, st, md, dr, stp, ps);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
